// File: rtl/beu_pipe.sv
// Two-stage branch execution unit: S1 holds the issued op and resolves it,
// S2 holds the tagged result for the ROB and raises a one-shot redirect on a mispredict.
module beu_pipe #(
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [1:0]           iss_jtype,
  input  logic [2:0]           iss_funct3,
  input  logic [XLEN-1:0]      iss_rs1,
  input  logic [XLEN-1:0]      iss_rs2,
  input  logic [XLEN-1:0]      iss_pc,
  input  logic [XLEN-1:0]      iss_imm,
  input  logic                 iss_pred_taken,
  input  logic [XLEN-1:0]      iss_pred_tgt,
  input  logic [ROB_TAG_W-1:0] iss_rob_tag,
  input  logic                 flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROB_TAG_W-1:0] res_rob_tag,
  output logic                 res_taken,
  output logic [XLEN-1:0]      res_next_pc,
  output logic [XLEN-1:0]      res_link,
  output logic                 res_mispredict,
  output logic                 res_misalign,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc
);

  typedef enum logic {RUN, WAIT_FLUSH} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  state_t state, next_state;

  logic                 s1_valid;
  logic [1:0]           s1_jtype;
  logic [2:0]           s1_funct3;
  logic [XLEN-1:0]      s1_rs1, s1_rs2, s1_pc, s1_imm, s1_pred_tgt;
  logic                 s1_pred_taken;
  logic [ROB_TAG_W-1:0] s1_tag;

  logic                 s2_valid;
  logic [ROB_TAG_W-1:0] s2_tag;
  logic                 s2_taken, s2_mispredict, s2_misalign, s2_redir_done;
  logic [XLEN-1:0]      s2_next_pc, s2_link;

  logic                 is_jal, is_jalr, cond_taken;
  logic                 r_taken, r_mispredict, r_misalign;
  logic [XLEN-1:0]      r_target, r_next_pc, r_link;
  logic                 s2_fire, s1_adv, iss_fire, mp_load;

  always_comb begin
    is_jal     = (s1_jtype == 2'b01);
    is_jalr    = (s1_jtype == 2'b10);
    cond_taken = 1'b0;
    case (s1_funct3)
      3'b000:  cond_taken = (s1_rs1 == s1_rs2);
      3'b001:  cond_taken = (s1_rs1 != s1_rs2);
      3'b100:  cond_taken = ($signed(s1_rs1) <  $signed(s1_rs2));
      3'b101:  cond_taken = ($signed(s1_rs1) >= $signed(s1_rs2));
      3'b110:  cond_taken = (s1_rs1 <  s1_rs2);
      3'b111:  cond_taken = (s1_rs1 >= s1_rs2);
      default: cond_taken = 1'b0;
    endcase
    r_taken      = (is_jal || is_jalr) ? 1'b1 : cond_taken;
    r_target     = is_jalr ? ((s1_rs1 + s1_imm) & ALIGN_MASK) : (s1_pc + s1_imm);
    r_link       = s1_pc + INSN_BYTES;
    r_next_pc    = r_taken ? r_target : r_link;
    r_mispredict = (r_taken != s1_pred_taken) || (r_taken && (r_target != s1_pred_tgt));
    r_misalign   = r_taken && r_target[1];
  end

  // Handshake/advance decisions and the RUN/WAIT_FLUSH next state.
  always_comb begin
    next_state = state;
    s2_fire    = s2_valid && res_ready;
    s1_adv     = s1_valid && (!s2_valid || s2_fire);
    iss_ready  = !rst && !flush && (state == RUN) && (!s1_valid || s1_adv);
    iss_fire   = iss_valid && iss_ready;
    mp_load    = s1_adv && r_mispredict;
    case (state)
      RUN:        if (mp_load) next_state = WAIT_FLUSH;
      WAIT_FLUSH: next_state = WAIT_FLUSH;
      default:    next_state = RUN;
    endcase
    if (flush) next_state = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // A mispredict entering S2 discards whatever is in S1 or being issued: it is younger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_jtype      <= '0;
      s1_funct3     <= '0;
      s1_rs1        <= '0;
      s1_rs2        <= '0;
      s1_pc         <= '0;
      s1_imm        <= '0;
      s1_pred_taken <= 1'b0;
      s1_pred_tgt   <= '0;
      s1_tag        <= '0;
    end else if (flush || mp_load) begin
      s1_valid <= 1'b0;
    end else if (iss_fire) begin
      s1_valid      <= 1'b1;
      s1_jtype      <= iss_jtype;
      s1_funct3     <= iss_funct3;
      s1_rs1        <= iss_rs1;
      s1_rs2        <= iss_rs2;
      s1_pc         <= iss_pc;
      s1_imm        <= iss_imm;
      s1_pred_taken <= iss_pred_taken;
      s1_pred_tgt   <= iss_pred_tgt;
      s1_tag        <= iss_rob_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // redir_done marks that the current S2 result has already spent a cycle visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      s2_tag        <= '0;
      s2_taken      <= 1'b0;
      s2_next_pc    <= '0;
      s2_link       <= '0;
      s2_mispredict <= 1'b0;
      s2_misalign   <= 1'b0;
      s2_redir_done <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid      <= 1'b1;
      s2_tag        <= s1_tag;
      s2_taken      <= r_taken;
      s2_next_pc    <= r_next_pc;
      s2_link       <= r_link;
      s2_mispredict <= r_mispredict;
      s2_misalign   <= r_misalign;
      s2_redir_done <= 1'b0;
    end else if (s2_fire) begin
      s2_valid <= 1'b0;
    end else if (s2_valid) begin
      s2_redir_done <= 1'b1;
    end
  end

  assign res_valid      = s2_valid;
  assign res_rob_tag    = s2_tag;
  assign res_taken      = s2_taken;
  assign res_next_pc    = s2_next_pc;
  assign res_link       = s2_link;
  assign res_mispredict = s2_mispredict;
  assign res_misalign   = s2_misalign;
  assign redirect_valid = s2_valid && s2_mispredict && !s2_redir_done;
  assign redirect_pc    = s2_next_pc;

endmodule

// File: tb/tb_beu_pipe.sv
// Self-checking bench for beu_pipe: directed test-plan cases plus randomized traffic
// checked every cycle against an in-order queue model of the unit.
module tb_beu_pipe;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_jtype;
  logic [2:0]  iss_funct3;
  logic [31:0] iss_rs1, iss_rs2, iss_pc, iss_imm, iss_pred_tgt;
  logic        iss_pred_taken;
  logic [5:0]  iss_rob_tag;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_rob_tag;
  logic        res_taken;
  logic [31:0] res_next_pc, res_link, redirect_pc;
  logic        res_mispredict, res_misalign, redirect_valid;

  beu_pipe #(.XLEN(32), .ROB_TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_jtype(iss_jtype), .iss_funct3(iss_funct3),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_pred_taken(iss_pred_taken), .iss_pred_tgt(iss_pred_tgt),
    .iss_rob_tag(iss_rob_tag), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_rob_tag(res_rob_tag),
    .res_taken(res_taken), .res_next_pc(res_next_pc), .res_link(res_link),
    .res_mispredict(res_mispredict), .res_misalign(res_misalign),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        mp;
    logic        mis;
    bit          visible;
    bit          fresh;
  } exp_t;

  exp_t q[$];
  bit   blocked;
  int   checks;
  int   fails;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic refTaken(input logic [1:0] jt, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
    if (jt == 2'd1 || jt == 2'd2) return 1'b1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refTarget(input logic [1:0] jt, input logic [31:0] a,
                                            input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] s;
    if (jt == 2'd2) begin
      s = a + imm;
      s[0] = 1'b0;
      return s;
    end
    return pc + imm;
  endfunction

  // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] jt, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptgt,
                               input logic [5:0] tag, input logic rr, input logic fl);
    bit   ev, er, issued;
    exp_t e;
    logic [31:0] tgt;
    iss_valid = v; iss_jtype = jt; iss_funct3 = f3; iss_rs1 = a; iss_rs2 = b;
    iss_pc = pc; iss_imm = imm; iss_pred_taken = pt; iss_pred_tgt = ptgt;
    iss_rob_tag = tag; res_ready = rr; flush = fl;
    #1;
    ev = (q.size() > 0) && q[0].visible;
    er = !blocked && !fl && (q.size() < 2 || rr);
    checkOutput("iss_ready", {31'd0, iss_ready}, {31'd0, er});
    checkOutput("res_valid", {31'd0, res_valid}, {31'd0, ev});
    checkOutput("redirect_valid", {31'd0, redirect_valid},
                {31'd0, ev && q[0].mp && q[0].fresh});
    if (ev) begin
      checkOutput("res_rob_tag", {26'd0, res_rob_tag}, {26'd0, q[0].tag});
      checkOutput("res_taken", {31'd0, res_taken}, {31'd0, q[0].taken});
      checkOutput("res_next_pc", res_next_pc, q[0].next_pc);
      checkOutput("res_link", res_link, q[0].link);
      checkOutput("res_mispredict", {31'd0, res_mispredict}, {31'd0, q[0].mp});
      checkOutput("res_misalign", {31'd0, res_misalign}, {31'd0, q[0].mis});
      checkOutput("redirect_pc", redirect_pc, q[0].next_pc);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      blocked = 0;
    end else begin
      issued = v && er;
      if (ev && rr) void'(q.pop_front());
      else if (ev) q[0].fresh = 0;
      if (q.size() > 0 && !q[0].visible) begin
        q[0].visible = 1;
        q[0].fresh   = 1;
        if (q[0].mp) begin
          blocked = 1;
          while (q.size() > 1) void'(q.pop_back());
          issued = 0;
        end
      end
      if (issued) begin
        e.tag     = tag;
        e.taken   = refTaken(jt == 2'd3 ? 2'd0 : jt, f3, a, b);
        tgt       = refTarget(jt, a, pc, imm);
        e.link    = pc + 32'd4;
        e.next_pc = e.taken ? tgt : e.link;
        e.mp      = (e.taken != pt) || (e.taken && tgt != ptgt);
        e.mis     = e.taken && tgt[1];
        e.visible = 0;
        e.fresh   = 0;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] jt, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt, input logic [5:0] tag,
                       input logic rr);
    applyStimulus(1'b1, jt, f3, a, b, pc, imm, pt, ptgt, tag, rr, 1'b0);
  endtask

  task automatic idle(input logic rr, input logic fl);
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0, rr, fl);
  endtask

  task automatic midReset();
    #1 rst = 1'b1;
    iss_valid = 1'b0;
    #1;
    checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset_redirect", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset_iss_ready", {31'd0, iss_ready}, 32'd0);
    q.delete();
    blocked = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic randomCycle();
    logic        v, rr, fl, pt;
    logic [1:0]  jt;
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm, ptgt, r;
    logic [11:0] r12;
    v  = ($urandom_range(0, 3) != 0);
    rr = ($urandom_range(0, 3) != 0);
    fl = blocked ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
    jt = 2'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7));
    a  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7));
    b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
    pc = $urandom;
    r12 = 12'($urandom);
    imm = {{20{r12[11]}}, r12};
    if ($urandom_range(0, 1) != 0) begin
      pt   = refTaken(jt == 2'd3 ? 2'd0 : jt, f3, a, b);
      ptgt = refTarget(jt, a, pc, imm);
    end else begin
      r    = $urandom;
      pt   = r[0];
      ptgt = ($urandom_range(0, 1) != 0) ? refTarget(jt, a, pc, imm) : $urandom;
    end
    applyStimulus(v, jt, f3, a, b, pc, imm, pt, ptgt, 6'($urandom), rr, fl);
  endtask

  initial begin
    checks = 0; fails = 0; blocked = 0;
    rst = 1'b1; iss_valid = 1'b0; iss_jtype = '0; iss_funct3 = '0; iss_rs1 = '0;
    iss_rs2 = '0; iss_pc = '0; iss_imm = '0; iss_pred_taken = 1'b0; iss_pred_tgt = '0;
    iss_rob_tag = '0; res_ready = 1'b0; flush = 1'b0;
    #2;
    checkOutput("por_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("por_iss_ready", {31'd0, iss_ready}, 32'd0);
    checkOutput("por_redirect", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] BEQ correctly predicted");
    issue(2'd0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 6'd3, 1'b1);
    idle(1'b0, 1'b0);
    checkOutput("beq_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("beq_taken", {31'd0, res_taken}, 32'd1);
    checkOutput("beq_next_pc", res_next_pc, 32'h120);
    checkOutput("beq_link", res_link, 32'h104);
    checkOutput("beq_mispredict", {31'd0, res_mispredict}, 32'd0);
    checkOutput("beq_redirect", {31'd0, redirect_valid}, 32'd0);
    idle(1'b1, 1'b0);

    $display("[TB] BLT vs BLTU");
    issue(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 32'd0, 6'd4, 1'b1);
    idle(1'b0, 1'b0);
    checkOutput("blt_taken", {31'd0, res_taken}, 32'd1);
    checkOutput("blt_next_pc", res_next_pc, 32'h340);
    checkOutput("blt_mispredict", {31'd0, res_mispredict}, 32'd1);
    checkOutput("blt_redirect", {31'd0, redirect_valid}, 32'd1);
    idle(1'b0, 1'b0);
    checkOutput("blt_redirect_stall", {31'd0, redirect_valid}, 32'd0);
    idle(1'b1, 1'b1);
    issue(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 32'd0, 6'd5, 1'b1);
    idle(1'b0, 1'b0);
    checkOutput("bltu_taken", {31'd0, res_taken}, 32'd0);
    checkOutput("bltu_next_pc", res_next_pc, 32'h304);
    checkOutput("bltu_mispredict", {31'd0, res_mispredict}, 32'd0);
    idle(1'b1, 1'b0);

    $display("[TB] JALR target and misalign");
    issue(2'd2, 3'd0, 32'h1003, 32'd0, 32'h200, 32'd2, 1'b1, 32'h1004, 6'd6, 1'b1);
    issue(2'd2, 3'd0, 32'h1001, 32'd0, 32'h210, 32'd1, 1'b1, 32'h1002, 6'd7, 1'b1);
    checkOutput("jalr0_next_pc", res_next_pc, 32'h1004);
    checkOutput("jalr0_link", res_link, 32'h204);
    checkOutput("jalr0_misalign", {31'd0, res_misalign}, 32'd0);
    idle(1'b1, 1'b0);
    checkOutput("jalr1_next_pc", res_next_pc, 32'h1002);
    checkOutput("jalr1_misalign", {31'd0, res_misalign}, 32'd1);
    idle(1'b1, 1'b0);

    $display("[TB] Backpressure");
    for (int i = 0; i < 4; i++)
      issue(2'd0, 3'd0, 32'(i), 32'(i), 32'h400 + 32'(16 * i), 32'd8, 1'b1,
            32'h408 + 32'(16 * i), 6'(10 + i), 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

    $display("[TB] Mispredict then flush");
    issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1, 32'h510, 6'd20, 1'b0);
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h504, 32'h80, 1'b1, 32'h584, 6'd21, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("mp_tag", {26'd0, res_rob_tag}, 32'd20);
    idle(1'b1, 1'b1);
    checkOutput("post_flush_valid", {31'd0, res_valid}, 32'd0);
    idle(1'b1, 1'b0);

    $display("[TB] Reset and flush mid-flight");
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h600, 32'h20, 1'b1, 32'h620, 6'd30, 1'b0);
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h620, 32'h20, 1'b1, 32'h640, 6'd31, 1'b0);
    midReset();
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h700, 32'h20, 1'b1, 32'h720, 6'd32, 1'b0);
    issue(2'd1, 3'd0, 32'd0, 32'd0, 32'h720, 32'h20, 1'b1, 32'h740, 6'd33, 1'b0);
    idle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

    $display("[TB] Randomized traffic");
    for (int i = 0; i < 800; i++) randomCycle();
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
